// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the seven-segment snake controller.
//   RING_LEN       number of positions on the outer segment ring
//   SEG_A..SEG_G   bit index of each segment inside a hex*_d word
//   state_t        game FSM states
//   ring_to_seg()  ring position -> (digit, segment bit); digit 3 is hex3
//   ring_add/sub() modular arithmetic on ring positions
package snake_pkg;

    localparam int RING_LEN = 12;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic [2:0] {
        IDLE,
        FOOD,
        RUN,
        PAUSE,
        WIN
    } state_t;

    typedef struct packed {
        logic [1:0] digit;
        logic [2:0] seg;
    } ring_seg_t;

    // Clockwise ring: top row left->right, right edge down,
    // bottom row right->left, left edge up.
    function automatic ring_seg_t ring_to_seg(input logic [3:0] pos);
        ring_seg_t r;
        r.digit = 2'd0;
        r.seg   = 3'(SEG_G);
        case (pos)
            4'd0:  begin r.digit = 2'd3; r.seg = 3'(SEG_A); end
            4'd1:  begin r.digit = 2'd2; r.seg = 3'(SEG_A); end
            4'd2:  begin r.digit = 2'd1; r.seg = 3'(SEG_A); end
            4'd3:  begin r.digit = 2'd0; r.seg = 3'(SEG_A); end
            4'd4:  begin r.digit = 2'd0; r.seg = 3'(SEG_B); end
            4'd5:  begin r.digit = 2'd0; r.seg = 3'(SEG_C); end
            4'd6:  begin r.digit = 2'd0; r.seg = 3'(SEG_D); end
            4'd7:  begin r.digit = 2'd1; r.seg = 3'(SEG_D); end
            4'd8:  begin r.digit = 2'd2; r.seg = 3'(SEG_D); end
            4'd9:  begin r.digit = 2'd3; r.seg = 3'(SEG_D); end
            4'd10: begin r.digit = 2'd3; r.seg = 3'(SEG_E); end
            4'd11: begin r.digit = 2'd3; r.seg = 3'(SEG_F); end
            default: ;
        endcase
        return r;
    endfunction

    // Both operands must already be in 0..RING_LEN-1.
    function automatic logic [3:0] ring_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 5'(RING_LEN)) ? 4'(s - 5'(RING_LEN)) : s[3:0];
    endfunction

    function automatic logic [3:0] ring_sub(input logic [3:0] a, input logic [3:0] b);
        return ring_add(a, 4'(RING_LEN) - b);
    endfunction

endpackage

// File: rtl/snake_btn_sync.sv
// snake_btn_sync: 2-FF synchronizer and falling-edge detector for the three
// active-low pushbuttons. One single-cycle pulse per press.
//   clk_i   system clock
//   rst_i   synchronous active-high reset (all buttons treated as released)
//   btn_i   raw active-low buttons
//   fall_o  one-cycle press pulses
module snake_btn_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] btn_i,
    output logic [2:0] fall_o
);

    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [2:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game on the 12-segment outer ring of a 4-digit display.
//   clk            system clock
//   rst            synchronous active-high reset
//   button[2:0]    active-low: [0] start/pause, [1] reverse, [2] restart
//   sw[3:0]        [1:0] speed (step period = TICK_DIV >> sw[1:0]); [3:2] unused
//   hex3_d..hex0_d active-low segments (bit0=a .. bit6=g), hex3 leftmost
//   p[3:0]         current snake length
// Optional build macro FOOD_BLINK_EN: food segment blinks on every tick.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 2500000,
    parameter int INIT_LEN = 2,
    parameter int MAX_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] button,
    input  logic [3:0] sw,
    output logic [6:0] hex0_d,
    output logic [6:0] hex1_d,
    output logic [6:0] hex2_d,
    output logic [6:0] hex3_d,
    output logic [3:0] p
);

    localparam int          CNT_W     = $clog2(TICK_DIV + 1);
    localparam logic [3:0]  INIT_HEAD = 4'(INIT_LEN - 1);
    localparam logic [3:0]  INIT_L    = 4'(INIT_LEN);
    localparam logic [3:0]  MAX_L     = 4'(MAX_LEN);

    state_t           state_q, state_d;
    logic [3:0]       head_q, head_d;
    logic [3:0]       len_q, len_d;
    logic             dir_ccw_q, dir_ccw_d;
    logic [3:0]       food_q, food_d;
    logic [3:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             win_on_q, win_on_d;
    logic [3:0][6:0]  hex_q, hex_d;
    logic [3:0]       p_q, p_d;
`ifdef FOOD_BLINK_EN
    logic             blink_q, blink_d;
`endif

    logic [2:0]       press;
    logic             start_p, rev_p, restart_p;
    logic [CNT_W-1:0] per_sel, lim;
    logic             tick;
    logic [11:0]      body_mask;
    logic [15:0]      body_ext;
    logic [11:0]      ring_mask;
    logic [3:0][6:0]  seg_on;
    logic [3:0]       body_pos;
    ring_seg_t        rs;
    logic [3:0]       next_head;
    logic [3:0]       cand;
    logic             food_vis;
    logic             unused_sw;

    snake_btn_sync u_btn (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (button),
        .fall_o (press)
    );

    assign start_p   = press[0];
    assign rev_p     = press[1];
    assign restart_p = press[2];
    assign unused_sw = ^sw[3:2];

    // The period is latched at each wrap so a speed change never cuts a step short.
    assign per_sel = CNT_W'(TICK_DIV >> sw[1:0]);
    assign lim     = (per_q == '0) ? '0 : per_q - CNT_W'(1);
    assign tick    = (cnt_q == lim);

    assign next_head = dir_ccw_q ? ring_sub(head_q, 4'd1) : ring_add(head_q, 4'd1);
    assign cand      = lfsr_q - 4'd1;

`ifdef FOOD_BLINK_EN
    assign food_vis = blink_q;
`else
    assign food_vis = 1'b1;
`endif

    // Body runs from the head backwards against the direction of travel.
    always_comb begin
        body_mask = '0;
        body_pos  = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (4'(i) < len_q) begin
                body_pos = dir_ccw_q ? ring_add(head_q, 4'(i)) : ring_sub(head_q, 4'(i));
                body_mask[body_pos] = 1'b1;
            end
        end
    end

    assign body_ext = {4'b0000, body_mask};

    always_comb begin
        ring_mask = body_mask;
        if (state_q == WIN) begin
            ring_mask = win_on_q ? '1 : '0;
        end else if ((state_q == RUN || state_q == PAUSE) && food_vis) begin
            ring_mask[food_q] = 1'b1;
        end
        seg_on = '0;
        rs     = '0;
        for (int unsigned i = 0; i < RING_LEN; i++) begin
            if (ring_mask[i]) begin
                rs = ring_to_seg(4'(i));
                seg_on[rs.digit][rs.seg] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        len_d     = len_q;
        dir_ccw_d = dir_ccw_q;
        food_d    = food_q;
        win_on_d  = win_on_q;
        lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        per_d     = tick ? per_sel : per_q;
        p_d       = len_q;
        hex_d     = ~seg_on;
`ifdef FOOD_BLINK_EN
        blink_d   = blink_q;
        if (tick && (state_q == RUN || state_q == PAUSE)) begin
            blink_d = ~blink_q;
        end
`endif

        if (restart_p) begin
            // Same as reset apart from the LFSR, which keeps running.
            state_d   = IDLE;
            head_d    = INIT_HEAD;
            len_d     = INIT_L;
            dir_ccw_d = 1'b0;
            food_d    = '0;
            win_on_d  = 1'b1;
            cnt_d     = '0;
            per_d     = per_sel;
            p_d       = INIT_L;
            hex_d     = '1;
`ifdef FOOD_BLINK_EN
            blink_d   = 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_p) state_d = FOOD;
                end
                FOOD: begin
                    if (cand < 4'(RING_LEN) && !body_ext[cand]) begin
                        food_d  = cand;
                        state_d = RUN;
`ifdef FOOD_BLINK_EN
                        blink_d = 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (start_p) begin
                        state_d = PAUSE;
                    end else if (rev_p) begin
                        // New head is the old tail; any tick this cycle is dropped.
                        head_d    = dir_ccw_q ? ring_add(head_q, len_q - 4'd1)
                                              : ring_sub(head_q, len_q - 4'd1);
                        dir_ccw_d = ~dir_ccw_q;
                    end else if (tick) begin
                        head_d = next_head;
                        if (next_head == food_q) begin
                            len_d = len_q + 4'd1;
                            if (len_q + 4'd1 == MAX_L) begin
                                state_d  = WIN;
                                win_on_d = 1'b1;
                            end else begin
                                state_d = FOOD;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start_p) state_d = RUN;
                end
                WIN: begin
                    if (tick) win_on_d = ~win_on_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            head_q    <= INIT_HEAD;
            len_q     <= INIT_L;
            dir_ccw_q <= 1'b0;
            food_q    <= '0;
            lfsr_q    <= 4'b0001;
            cnt_q     <= '0;
            per_q     <= per_sel;
            win_on_q  <= 1'b1;
            hex_q     <= '1;
            p_q       <= INIT_L;
`ifdef FOOD_BLINK_EN
            blink_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            len_q     <= len_d;
            dir_ccw_q <= dir_ccw_d;
            food_q    <= food_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            win_on_q  <= win_on_d;
            hex_q     <= hex_d;
            p_q       <= p_d;
`ifdef FOOD_BLINK_EN
            blink_q   <= blink_d;
`endif
        end
    end

    assign hex3_d = hex_q[3];
    assign hex2_d = hex_q[2];
    assign hex1_d = hex_q[1];
    assign hex0_d = hex_q[0];
    assign p      = p_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: randomized bench for snake_ctrl. A reference model keeps the
// snake as a queue of ring positions (head first) and predicts the display and
// length each cycle; a separate monitor pops predictions and compares.
module tb_snake_ctrl;

    localparam int TD = 4;
    localparam int IL = 2;
    localparam int ML = 8;

    localparam int M_IDLE  = 0;
    localparam int M_FOOD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_WIN   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] button = 3'b111;
    logic [3:0] sw = 4'b0000;
    logic [6:0] hex0_d, hex1_d, hex2_d, hex3_d;
    logic [3:0] p;

    always #5 clk = ~clk;

    snake_ctrl #(.TICK_DIV(TD), .INIT_LEN(IL), .MAX_LEN(ML)) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .sw     (sw),
        .hex0_d (hex0_d),
        .hex1_d (hex1_d),
        .hex2_d (hex2_d),
        .hex3_d (hex3_d),
        .p      (p)
    );

    typedef struct packed {
        logic [6:0] h3;
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
        logic [3:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   timeout_flag = 1'b0;
    bit   timeout_seen = 1'b0;

    // Ring position -> digit / segment bit
    int seg_dig[12];
    int seg_bit[12];
    initial begin
        for (int k = 0; k < 4; k++) begin seg_dig[k] = 3 - k; seg_bit[k] = 0; end
        seg_dig[4] = 0; seg_bit[4] = 1;
        seg_dig[5] = 0; seg_bit[5] = 2;
        for (int k = 6; k < 10; k++) begin seg_dig[k] = k - 6; seg_bit[k] = 3; end
        seg_dig[10] = 3; seg_bit[10] = 4;
        seg_dig[11] = 3; seg_bit[11] = 5;
    end

    // Reference model state
    int         body[$];
    int         m_mode, m_dir, m_food, m_lfsr, m_left, m_per;
    bit         m_win_on;
    bit         m_live = 1'b0;
    logic [2:0] hist0, hist1, hist2;

    function automatic void model_reset(bit full);
        body.delete();
        for (int i = 0; i < IL; i++) body.push_back(IL - 1 - i);
        m_dir    = 1;
        m_mode   = M_IDLE;
        m_food   = 0;
        m_per    = TD >> sw[1:0];
        m_left   = m_per - 1;
        m_win_on = 1'b1;
        if (full) begin
            m_lfsr = 1;
            hist0  = 3'b111;
            hist1  = 3'b111;
            hist2  = 3'b111;
        end
    endfunction

    function automatic bit in_body(int pos);
        foreach (body[i]) if (body[i] == pos) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t render();
        exp_t       e;
        logic [6:0] hx[4];
        bit         occ[12];
        for (int k = 0; k < 12; k++) occ[k] = 1'b0;
        if (m_mode == M_WIN) begin
            for (int k = 0; k < 12; k++) occ[k] = m_win_on;
        end else begin
            foreach (body[i]) occ[body[i]] = 1'b1;
            if (m_mode == M_RUN || m_mode == M_PAUSE) occ[m_food] = 1'b1;
        end
        for (int d = 0; d < 4; d++) hx[d] = 7'h7F;
        for (int k = 0; k < 12; k++) if (occ[k]) hx[seg_dig[k]][seg_bit[k]] = 1'b0;
        e.h3 = hx[3]; e.h2 = hx[2]; e.h1 = hx[1]; e.h0 = hx[0];
        e.p  = 4'(body.size());
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t       e;
        logic [2:0] pulse;
        bit         tk;
        int         cand, n;
        int         tmp[$];
        if (rst) begin
            model_reset(1'b1);
            m_live = 1'b1;
            e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'(IL)};
            exp_q.push_back(e);
        end else if (m_live) begin
            pulse = hist2 & ~hist1;
            hist2 = hist1;
            hist1 = hist0;
            hist0 = button;
            cand   = m_lfsr - 1;
            m_lfsr = ((m_lfsr << 1) & 14) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
            if (pulse[2]) begin
                e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'(IL)};
                model_reset(1'b0);
            end else begin
                e  = render();
                tk = (m_left == 0);
                if (tk) begin
                    m_per  = TD >> sw[1:0];
                    m_left = m_per - 1;
                end else begin
                    m_left = m_left - 1;
                end
                case (m_mode)
                    M_IDLE: if (pulse[0]) m_mode = M_FOOD;
                    M_FOOD: begin
                        if (cand < 12 && !in_body(cand)) begin
                            m_food = cand;
                            m_mode = M_RUN;
                        end
                    end
                    M_RUN: begin
                        if (pulse[0]) begin
                            m_mode = M_PAUSE;
                        end else if (pulse[1]) begin
                            tmp.delete();
                            foreach (body[i]) tmp.push_front(body[i]);
                            body  = tmp;
                            m_dir = -m_dir;
                        end else if (tk) begin
                            n = (body[0] + m_dir + 12) % 12;
                            body.push_front(n);
                            if (n == m_food) begin
                                if (body.size() == ML) begin
                                    m_mode   = M_WIN;
                                    m_win_on = 1'b1;
                                end else begin
                                    m_mode = M_FOOD;
                                end
                            end else begin
                                void'(body.pop_back());
                            end
                        end
                    end
                    M_PAUSE: if (pulse[0]) m_mode = M_RUN;
                    M_WIN:   if (tk) m_win_on = ~m_win_on;
                    default: ;
                endcase
            end
            exp_q.push_back(e);
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({hex3_d, hex2_d, hex1_d, hex0_d, p} !== e) begin
                miscompares++;
                $display("FAIL display @%0t: got h3=%h h2=%h h1=%h h0=%h p=%0d, want h3=%h h2=%h h1=%h h0=%h p=%0d",
                         $time, hex3_d, hex2_d, hex1_d, hex0_d, p, e.h3, e.h2, e.h1, e.h0, e.p);
            end
        end
        if (timeout_flag && !timeout_seen) begin
            timeout_seen = 1'b1;
            vectors++;
            miscompares++;
            $display("FAIL win_timeout: model mode=%0d, want %0d within cycle budget", m_mode, M_WIN);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [2:0] m);
        button = ~m;
        cycles(3);
        button = 3'b111;
        cycles(3);
    endtask

    initial begin
        int r, cnt;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(3);
        press(3'b001);
        cycles(40);

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      cycles($urandom_range(1, 12));
            else if (r < 60) press(3'b001);
            else if (r < 78) press(3'b010);
            else if (r < 83) press(3'b100);
            else if (r < 91) begin
                sw[3:2] = 2'($urandom_range(0, 3));
                sw[1:0] = 2'($urandom_range(0, 2));
                cycles(1);
            end else if (r < 94) begin
                rst = 1'b1;
                cycles($urandom_range(1, 2));
                rst = 1'b0;
                cycles(2);
            end else begin
                press(3'($urandom_range(1, 7)));
            end
        end

        // Drive a game through to the win state, then probe it.
        press(3'b100);
        press(3'b001);
        cnt = 0;
        while (m_mode != M_WIN && cnt < 5000) begin
            cycles(1);
            cnt++;
        end
        if (m_mode != M_WIN) begin
            timeout_flag = 1'b1;
            cycles(2);
        end else begin
            cycles(20);
            press(3'b001);
            press(3'b010);
            cycles(20);
            press(3'b100);
            cycles(10);
        end

        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
